date_stepper: RTL and testbench
===============================

# date_stepper

Sequential date source that sits directly upstream of the day-of-week lookup stage. It holds a Gregorian calendar date in the range 1755-01-01 to 2033-12-31 and either loads a new date or advances it by one day per `step`. It presents registered `year`/`month`/`day` plus a one-cycle update strobe, which the lookup stage consumes. Out-of-range loads and attempts to step past the end of the range raise an error flag.

## Interface
- `MIN_YEAR`, 1755: first supported year; reset date is MIN_YEAR-01-01.
- `MAX_YEAR`, 2033: last supported year.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  load `load_year`/`load_month`/`load_day` this cycle.
- `load_year`  in  16  year to load, binary.
- `load_month`  in  4  month to load, 1..12.
- `load_day`  in  5  day to load, 1..31.
- `load_dow`  in  3  day of week of the loaded date, 0=Sun..6=Sat; used only with DATE_STEPPER_DOW_EN.
- `step`  in  1  advance the held date by one day.
- `year`  out  16  current year.
- `month`  out  4  current month, 1..12.
- `day`  out  5  current day, 1..31.
- `dow`  out  3  tracked day of week; 0 without the macro.
- `upd`  out  1  one-cycle pulse: date outputs changed or were reloaded.
- `err`  out  1  sticky error flag.

## Operation
- Reset: year=MIN_YEAR, month=1, day=1, dow=3 (Wednesday), upd=0, err=0.
- Priority each cycle: `load` over `step`. If both are high, the load is performed and the step is dropped.
- Load validity: MIN_YEAR ≤ load_year ≤ MAX_YEAR, 1 ≤ load_month ≤ 12, 1 ≤ load_day ≤ days_in(load_year, load_month).
  - Valid load: registers take the loaded values, err cleared, upd=1.
  - Invalid load: registers unchanged, err=1, upd=0.
- Step, normal case: day+1.
- Step at month end (day == days_in): day=1 and month+1.
- Step at Dec 31: day=1, month=1, year+1.
- Step at MAX_YEAR-12-31: date holds, err=1, upd=0 (saturate; no wrap).
- Successful step: upd=1. It does not clear err; only a valid load or reset clears err.
- Leap rule (Gregorian): leap if divisible by 4 and not by 100, or divisible by 400. Feb has 29 days in leap years, otherwise 28. Within range, 1800 and 1900 are not leap years; 2000 is.
- Month lengths: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11.
- Arithmetic: compare and increment at port widths. Leap test uses year mod 4, mod 100, mod 400 on the 16-bit year. No out-of-range value is ever stored.

## Timing
- All outputs are registered and change only on a rising `clk` edge or asynchronously on `reset`.
- Latency: `load`/`step` sampled at edge N; new date and `upd` visible after edge N, held until the next edge.
- `upd` is high for exactly one cycle per accepted load or step.
- Back-to-back `step` every cycle is supported: one day per cycle, `upd` high continuously.
- Reset mid-operation: immediate return to reset values; any pending load or step is discarded.
- `err` changes only on invalid load (set), saturating step (set), valid load (clear), or reset (clear).

## Configuration
- `DATE_STEPPER_DOW_EN` defined:
  - `dow` tracks the weekday: +1 mod 7 on each successful step.
  - Valid load sets `dow` = `load_dow`; `load_dow` is not range-checked beyond 0..6, and 7 loads as 0.
  - Saturating step leaves `dow` unchanged.
- Undefined: `dow` is constant 0, `load_dow` is ignored, and no weekday register is built.

## Structure
- Shared package `cal_pkg`:
  - Constants MIN_YEAR=1755, MAX_YEAR=2033.
  - Weekday encoding 0=Sun..6=Sat, and RESET_DOW=3.
  - Function `is_leap(year)`.
  - These are shared with the downstream lookup stage.
- One combinational sub-module `month_len` (year, month → days 28..31), instantiated twice: once for the held date (step path) and once for the load inputs (validity check).

## Test plan
- Reset, then one `step` → 1755-01-02, dow=4, upd pulses once, err=0.
- Load 1900-02-28 then step → 1900-03-01. Load 2000-02-28 then step twice → 2000-02-29, then 2000-03-01.
- Load 1999-12-31 (dow=5) then step → 2000-01-01, dow=6.
- Load 2033-12-31 then step → date holds, err=1, upd=0. Then load 2001-04-30 → err=0, date loaded.
- Invalid loads 1754-06-01, 1901-02-29, 2010-13-01, 2010-04-31 → err=1, date unchanged, no upd.
- `load` and `step` high together with load 2020-07-04 → 2020-07-04, not 07-05. Assert `reset` during continuous stepping → 1755-01-01 immediately, upd=0.

Source files
------------

// File: rtl/cal_pkg.sv
// Calendar package shared by the date stepper and the downstream
// day-of-week lookup stage: supported year range, weekday encoding,
// and the Gregorian leap-year test.
package cal_pkg;

  localparam logic [15:0] MIN_YEAR = 16'd1755;
  localparam logic [15:0] MAX_YEAR = 16'd2033;

  // Weekday encoding, Sunday first.
  typedef enum logic [2:0] {
    DOW_SUN = 3'd0,
    DOW_MON = 3'd1,
    DOW_TUE = 3'd2,
    DOW_WED = 3'd3,
    DOW_THU = 3'd4,
    DOW_FRI = 3'd5,
    DOW_SAT = 3'd6
  } dow_e;

  // 1755-01-01 fell on a Wednesday.
  localparam logic [2:0] RESET_DOW = DOW_WED;

  // Gregorian rule: every 4th year, except centuries not divisible by 400.
  function automatic logic is_leap(input logic [15:0] year);
    logic div4;
    logic div100;
    logic div400;
    div4   = ((year % 16'd4)   == 16'd0);
    div100 = ((year % 16'd100) == 16'd0);
    div400 = ((year % 16'd400) == 16'd0);
    return (div4 && !div100) || div400;
  endfunction

endpackage

// File: rtl/month_len.sv
// Combinational month length lookup: (year, month) -> 28..31 days.
// Months outside 1..12 report 31; callers range-check the month separately.
module month_len
  import cal_pkg::*;
(
  input  logic [15:0] year_i,
  input  logic [3:0]  month_i,
  output logic [4:0]  days_o
);

  // Select the length of the month, February depending on the leap test.
  always_comb begin
    days_o = 5'd31;
    case (month_i)
      4'd2:    days_o = is_leap(year_i) ? 5'd29 : 5'd28;
      4'd4,
      4'd6,
      4'd9,
      4'd11:   days_o = 5'd30;
      default: days_o = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_stepper.sv
// Date source feeding the day-of-week lookup stage. Holds a date in
// MIN_YEAR-01-01 .. MAX_YEAR-12-31, loads a new one or advances one day
// per step, and pulses upd whenever the outputs take a new date.
// Optional weekday tracking is built when DATE_STEPPER_DOW_EN is defined.
module date_stepper
  import cal_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_year,
  input  logic [3:0]  load_month,
  input  logic [4:0]  load_day,
  input  logic [2:0]  load_dow,
  input  logic        step,
  output logic [15:0] year,
  output logic [3:0]  month,
  output logic [4:0]  day,
  output logic [2:0]  dow,
  output logic        upd,
  output logic        err
);

  logic [15:0] year_q,  year_d;
  logic [3:0]  month_q, month_d;
  logic [4:0]  day_q,   day_d;
  logic        upd_q,   upd_d;
  logic        err_q,   err_d;

  logic [4:0]  cur_days_s;
  logic [4:0]  load_days_s;
  logic        load_ok_s;
  logic        at_end_s;
  logic        step_ok_s;

  // Length of the held month drives the step rollover.
  month_len u_cur_len (
    .year_i  (year_q),
    .month_i (month_q),
    .days_o  (cur_days_s)
  );

  // Length of the requested month bounds the load day.
  month_len u_load_len (
    .year_i  (load_year),
    .month_i (load_month),
    .days_o  (load_days_s)
  );

  // Load validity and step-saturation decode.
  always_comb begin
    load_ok_s = (load_year  >= MIN_YEAR) && (load_year  <= MAX_YEAR) &&
                (load_month >= 4'd1)     && (load_month <= 4'd12)    &&
                (load_day   >= 5'd1)     && (load_day   <= load_days_s);
    at_end_s  = (year_q == MAX_YEAR) && (month_q == 4'd12) && (day_q == 5'd31);
    step_ok_s = !load && step && !at_end_s;
  end

  // Next-state for the date, update strobe and sticky error; load wins over step.
  always_comb begin
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    upd_d   = 1'b0;
    err_d   = err_q;
    if (load) begin
      if (load_ok_s) begin
        year_d  = load_year;
        month_d = load_month;
        day_d   = load_day;
        upd_d   = 1'b1;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end else if (step) begin
      if (at_end_s) begin
        err_d = 1'b1;
      end else if (day_q >= cur_days_s) begin
        day_d = 5'd1;
        upd_d = 1'b1;
        if (month_q == 4'd12) begin
          month_d = 4'd1;
          year_d  = year_q + 16'd1;
        end else begin
          month_d = month_q + 4'd1;
        end
      end else begin
        day_d = day_q + 5'd1;
        upd_d = 1'b1;
      end
    end else begin
      upd_d = 1'b0;
    end
  end

  // Date, strobe and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      year_q  <= MIN_YEAR;
      month_q <= 4'd1;
      day_q   <= 5'd1;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

`ifdef DATE_STEPPER_DOW_EN
  logic [2:0] dow_q, dow_d;

  // Weekday follows loads (7 folds to Sunday) and advances mod 7 per step.
  always_comb begin
    dow_d = dow_q;
    if (load && load_ok_s) begin
      dow_d = (load_dow == 3'd7) ? 3'd0 : load_dow;
    end else if (step_ok_s) begin
      dow_d = (dow_q >= 3'd6) ? 3'd0 : dow_q + 3'd1;
    end else begin
      dow_d = dow_q;
    end
  end

  // Weekday register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dow_q <= RESET_DOW;
    end else begin
      dow_q <= dow_d;
    end
  end

  assign dow = dow_q;
`else
  // Weekday input has no consumer in this build.
  logic unused_dow_s;
  assign unused_dow_s = ^{load_dow, step_ok_s};
  assign dow = 3'd0;
`endif

  assign year  = year_q;
  assign month = month_q;
  assign day   = day_q;
  assign upd   = upd_q;
  assign err   = err_q;

endmodule

// File: tb/tb_date_stepper.sv
// Directed bench for date_stepper: hand-computed dates, strobe and error
// expectations. Weekday expectations collapse to 0 unless
// DATE_STEPPER_DOW_EN is defined.
module tb_date_stepper;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] load_year;
  logic [3:0]  load_month;
  logic [4:0]  load_day;
  logic [2:0]  load_dow;
  logic        step;
  logic [15:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [2:0]  dow;
  logic        upd;
  logic        err;

  int checks;
  int failures;

  date_stepper dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_year  (load_year),
    .load_month (load_month),
    .load_day   (load_day),
    .load_dow   (load_dow),
    .step       (step),
    .year       (year),
    .month      (month),
    .day        (day),
    .dow        (dow),
    .upd        (upd),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_dow(input logic [2:0] d);
`ifdef DATE_STEPPER_DOW_EN
    return d;
`else
    return 3'd0 & d;
`endif
  endfunction

  task automatic check_date(input string tag, input int y, input int m, input int d,
                            input logic [2:0] w, input logic u, input logic e);
    check_val({tag, ".year"},  32'(year),  32'(y));
    check_val({tag, ".month"}, 32'(month), 32'(m));
    check_val({tag, ".day"},   32'(day),   32'(d));
    check_val({tag, ".dow"},   32'(dow),   32'(exp_dow(w)));
    check_val({tag, ".upd"},   32'(upd),   32'(u));
    check_val({tag, ".err"},   32'(err),   32'(e));
  endtask

  // One cycle with the given controls applied on the falling edge; returns
  // 1 ns after the rising edge with controls released.
  task automatic apply(input logic l, input logic s, input int y, input int m,
                       input int d, input logic [2:0] w);
    @(negedge clk);
    load       = l;
    step       = s;
    load_year  = 16'(y);
    load_month = 4'(m);
    load_day   = 5'(d);
    load_dow   = w;
    @(posedge clk);
    #1;
    load = 1'b0;
    step = 1'b0;
  endtask

  task automatic do_load(input int y, input int m, input int d, input logic [2:0] w);
    apply(1'b1, 1'b0, y, m, d, w);
  endtask

  task automatic do_step();
    apply(1'b0, 1'b1, 0, 0, 0, 3'd0);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 0, 0, 0, 3'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    load       = 1'b0;
    step       = 1'b0;
    load_year  = 16'd0;
    load_month = 4'd0;
    load_day   = 5'd0;
    load_dow   = 3'd0;

    #12;
    check_date("reset", 1755, 1, 1, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    do_step();
    check_date("first_step", 1755, 1, 2, 3'd4, 1'b1, 1'b0);
    idle();
    check_val("upd_one_cycle", 32'(upd), 32'd0);

    do_load(1900, 2, 28, 3'd3);
    check_date("load_1900", 1900, 2, 28, 3'd3, 1'b1, 1'b0);
    do_step();
    check_date("step_1900_feb", 1900, 3, 1, 3'd4, 1'b1, 1'b0);

    do_load(2000, 2, 28, 3'd1);
    do_step();
    check_date("step_2000_feb28", 2000, 2, 29, 3'd2, 1'b1, 1'b0);
    do_step();
    check_date("step_2000_feb29", 2000, 3, 1, 3'd3, 1'b1, 1'b0);

    do_load(1999, 12, 31, 3'd5);
    do_step();
    check_date("step_year_wrap", 2000, 1, 1, 3'd6, 1'b1, 1'b0);

    do_load(2033, 12, 31, 3'd6);
    do_step();
    check_date("step_saturate", 2033, 12, 31, 3'd6, 1'b0, 1'b1);
    do_load(2001, 4, 30, 3'd1);
    check_date("load_clears_err", 2001, 4, 30, 3'd1, 1'b1, 1'b0);

    do_load(1754, 6, 1, 3'd2);
    check_date("bad_year", 2001, 4, 30, 3'd1, 1'b0, 1'b1);
    do_load(1901, 2, 29, 3'd2);
    check_date("bad_feb29", 2001, 4, 30, 3'd1, 1'b0, 1'b1);
    do_load(2010, 13, 1, 3'd2);
    check_date("bad_month", 2001, 4, 30, 3'd1, 1'b0, 1'b1);
    do_load(2010, 4, 31, 3'd2);
    check_date("bad_apr31", 2001, 4, 30, 3'd1, 1'b0, 1'b1);

    do_step();
    check_date("step_keeps_err", 2001, 5, 1, 3'd2, 1'b1, 1'b1);

    do_load(2010, 1, 1, 3'd7);
    check_date("load_dow7", 2010, 1, 1, 3'd0, 1'b1, 1'b0);

    apply(1'b1, 1'b1, 2020, 7, 4, 3'd6);
    check_date("load_over_step", 2020, 7, 4, 3'd6, 1'b1, 1'b0);

    @(negedge clk);
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_date("cont_step", 2020, 7, 5 + i, 3'((7 + i) % 7), 1'b1, 1'b0);
    end
    #2;
    reset = 1'b1;
    #1;
    check_date("mid_reset", 1755, 1, 1, 3'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_date("reset_held", 1755, 1, 1, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    step  = 1'b0;
    reset = 1'b0;
    idle();
    check_date("after_reset", 1755, 1, 1, 3'd3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
